// File: rtl/fifo_uart_tx.sv
// Drains a byte-wide FIFO one entry at a time and serializes each byte as UART 8N1, LSB first.
// All outputs are registered; tx idles high and only moves on bit boundaries.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_en,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  input  logic [7:0]       fifo_data,
  output logic             tx,
  output logic             busy,
  output logic             tx_done,
  output logic [CNT_W-1:0] frames_sent
);

  localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudMax = BaudW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StStart,
    StData,
    StStop
  } state_e;

  state_e           state_q;
  logic [7:0]       shift_q;
  logic [BaudW-1:0] baud_q;
  logic [2:0]       bit_idx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      shift_q     <= 8'h00;
      baud_q      <= '0;
      bit_idx_q   <= 3'd0;
      fifo_rd     <= 1'b0;
      tx          <= 1'b1;
      busy        <= 1'b0;
      tx_done     <= 1'b0;
      frames_sent <= '0;
    end else begin
      fifo_rd <= 1'b0;
      tx_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          baud_q <= '0;
          if (tx_en && !fifo_empty) begin
            state_q <= StFetch;
            fifo_rd <= 1'b1;
            busy    <= 1'b1;
          end
        end
        // fifo_data becomes valid after the edge that closes this cycle.
        StFetch: state_q <= StLoad;
        StLoad: begin
          shift_q <= fifo_data;
          baud_q  <= '0;
          tx      <= 1'b0;
          state_q <= StStart;
        end
        StStart: begin
          if (baud_q == BaudMax) begin
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            tx        <= shift_q[0];
            shift_q   <= {1'b0, shift_q[7:1]};
            state_q   <= StData;
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        StData: begin
          if (baud_q == BaudMax) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              tx      <= 1'b1;
              state_q <= StStop;
            end else begin
              tx        <= shift_q[0];
              shift_q   <= {1'b0, shift_q[7:1]};
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        StStop: begin
          if (baud_q == BaudMax) begin
            baud_q      <= '0;
            tx_done     <= 1'b1;
            frames_sent <= frames_sent + CNT_W'(1);
            busy        <= 1'b0;
            state_q     <= StIdle;
          end else begin
            baud_q <= baud_q + BaudW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          tx      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural FIFO, scoreboard of expected bytes, serial-line monitor.
module tb_fifo_uart_tx;

  localparam int CPB   = 4;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             tx_en;
  logic             fifo_empty;
  logic             fifo_rd;
  logic [7:0]       fifo_data = 8'h00;
  logic             tx;
  logic             busy;
  logic             tx_done;
  logic [CNT_W-1:0] frames_sent;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Behavioural FIFO: registered data_out, popped by an accepted rd.
  logic [7:0] mem [256];
  int push_cnt = 0;
  int pop_cnt = 0;
  logic [7:0] exp_q [$];
  int rd_cyc [$];
  int sent_total = 0;
  int mon_frames = 0;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .tx_en(tx_en),
    .fifo_empty(fifo_empty),
    .fifo_rd(fifo_rd),
    .fifo_data(fifo_data),
    .tx(tx),
    .busy(busy),
    .tx_done(tx_done),
    .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign fifo_empty = (push_cnt == pop_cnt);

  always @(posedge clk) begin
    if (fifo_rd && push_cnt != pop_cnt) begin
      fifo_data <= mem[pop_cnt[7:0]];
      pop_cnt   <= pop_cnt + 1;
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  task automatic push(input logic [7:0] b);
    mem[push_cnt[7:0]] = b;
    exp_q.push_back(b);
    push_cnt++;
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (push_cnt == pop_cnt && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_reached", 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_start(output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx == 1'b0) begin
        at_cyc = cyc;
        break;
      end
    end
  endtask

  // Read strobe monitor: log the cycle of every pop; a pop must never see an empty FIFO.
  always @(negedge clk) begin
    if (rst && fifo_rd) begin
      rd_cyc.push_back(cyc);
      chk("rd_nonempty", 32'(fifo_empty), 32'd0);
    end
  end

  // Serial monitor: decode each frame and compare against the scoreboard.
  initial begin : monitor
    logic [7:0] want;
    logic [7:0] got;
    logic [9:0] lvl;
    logic       bad;
    logic       aborted;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mon_frames = 0;
      end else if (tx == 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame actual=start_bit required=idle (t=%0t)", $time);
          want = 8'h00;
        end else begin
          want = exp_q.pop_front();
        end
        lvl = {1'b1, want, 1'b0};
        bad = 1'b0;
        aborted = 1'b0;
        got = 8'h00;
        for (int idx = 0; idx <= 40; idx++) begin
          if (idx > 0) @(negedge clk);
          if (!rst) begin
            aborted = 1'b1;
            mon_frames = 0;
            break;
          end
          if (idx < 40) begin
            if (tx !== lvl[idx / CPB] || tx_done !== 1'b0) bad = 1'b1;
            if (idx >= CPB && idx < 9 * CPB && (idx % CPB) == CPB / 2)
              got[idx / CPB - 1] = tx;
          end
        end
        if (!aborted) begin
          mon_frames++;
          chk("frame_shape", 32'(bad), 32'd0);
          chk("rx_byte", 32'(got), 32'(want));
          chk("tx_done_pulse", 32'(tx_done), 32'd1);
          chk("frames_sent_frame", 32'(frames_sent), 32'(mon_frames % (1 << CNT_W)));
          @(negedge clk);
          chk("tx_done_single", 32'(tx_done), 32'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n0;
    int p0;
    int c0;
    int st;
    logic bad;
    rst   = 1'b0;
    tx_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_rd", 32'(fifo_rd), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(tx_done), 32'd0);
    chk("reset_frames", 32'(frames_sent), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte.
    tx_en = 1'b1;
    n0 = rd_cyc.size();
    push(8'hA5);
    sent_total++;
    wait_idle();
    chk("t1_rd_count", 32'(rd_cyc.size() - n0), 32'd1);
    chk("t1_frames", 32'(frames_sent), 32'(sent_total % 4));
    chk("t1_empty", 32'(fifo_empty), 32'd1);

    // Back-to-back.
    n0 = rd_cyc.size();
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    sent_total += 3;
    wait_idle();
    chk("t2_rd_count", 32'(rd_cyc.size() - n0), 32'd3);
    if (rd_cyc.size() - n0 == 3) begin
      chk("t2_gap1", 32'(rd_cyc[n0 + 1] - rd_cyc[n0]), 32'(10 * CPB + 3));
      chk("t2_gap2", 32'(rd_cyc[n0 + 2] - rd_cyc[n0 + 1]), 32'(10 * CPB + 3));
    end
    chk("t2_frames", 32'(frames_sent), 32'(sent_total % 4));

    // Flow gate: bytes queued while tx_en is low.
    tx_en = 1'b0;
    n0 = rd_cyc.size();
    p0 = pop_cnt;
    push(8'h5A);
    push(8'h81);
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (fifo_rd !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    chk("t3_gated_quiet", 32'(bad), 32'd0);
    chk("t3_gated_no_pop", 32'(pop_cnt - p0), 32'd0);
    tx_en = 1'b1;
    sent_total += 2;
    wait_idle();
    chk("t3_rd_count", 32'(rd_cyc.size() - n0), 32'd2);

    // Drop tx_en during a data bit: that frame finishes, the next byte stays queued.
    n0 = rd_cyc.size();
    push(8'hC3);
    push(8'h96);
    wait_start(st);
    repeat (8) @(negedge clk);
    tx_en = 1'b0;
    sent_total++;
    repeat (60) @(negedge clk);
    chk("t3_drop_rd_count", 32'(rd_cyc.size() - n0), 32'd1);
    chk("t3_drop_busy", 32'(busy), 32'd0);
    chk("t3_drop_left", 32'(push_cnt - pop_cnt), 32'd1);
    chk("t3_drop_frames", 32'(frames_sent), 32'(sent_total % 4));

    // Reset during data bit 3 of 0x96; 0x4B follows and must go out intact.
    push(8'h4B);
    tx_en = 1'b1;
    wait_start(st);
    repeat (4 + 3 * CPB + CPB / 2) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("t4_async_tx", 32'(tx), 32'd1);
    chk("t4_async_busy", 32'(busy), 32'd0);
    chk("t4_async_frames", 32'(frames_sent), 32'd0);
    sent_total = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sent_total++;
    wait_idle();
    chk("t4_frames", 32'(frames_sent), 32'(sent_total % 4));

    // Empty FIFO, then a late byte: rd next cycle, start bit three edges after.
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (fifo_rd !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) bad = 1'b1;
    end
    chk("t5_empty_quiet", 32'(bad), 32'd0);
    @(posedge clk);
    #1;
    c0 = cyc;
    push(8'h6E);
    sent_total++;
    @(negedge clk);
    chk("t5_rd_not_yet", 32'(fifo_rd), 32'd0);
    @(negedge clk);
    chk("t5_rd_next", 32'(fifo_rd), 32'd1);
    wait_start(st);
    chk("t5_start_latency", 32'(st - c0), 32'd3);
    wait_idle();

    // Counter wrap: five frames after a fresh reset.
    rst = 1'b0;
    sent_total = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    push(8'h01);
    push(8'h80);
    push(8'h7E);
    push(8'hE7);
    push(8'h33);
    sent_total += 5;
    wait_idle();
    chk("t6_frames_wrap", 32'(frames_sent), 32'(sent_total % 4));
    chk("t6_monitor_frames", 32'(mon_frames), 32'd5);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream drain stage for the 8-bit, 32-deep synchronous FIFO. It pops one byte at a time over the FIFO's rd/empty/data_out interface and serializes it as UART 8N1, LSB first, on a single tx line. It sits between the FIFO read port and the chip pad, and shares the FIFO's clock.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit; legal range >= 2.
CNT_W, 16, width of the frames_sent counter.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  asynchronous, active-low reset.
tx_en  input  1  allows new frames to start; a frame already in progress always completes.
fifo_empty  input  1  FIFO empty flag.
fifo_rd  output  1  FIFO read strobe; registered.
fifo_data  input  8  FIFO data_out; registered in the FIFO, valid the cycle after an accepted rd.
tx  output  1  serial line; idles high.
busy  output  1  high from FETCH through STOP.
tx_done  output  1  one-cycle pulse at the end of each stop bit.
frames_sent  output  CNT_W  count of completed frames; wraps to 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - tx=1, fifo_rd=0, busy=0, tx_done=0, frames_sent=0.
  - State=IDLE; shift register, baud counter and bit index cleared.
  - Reset mid-frame aborts the frame immediately. The popped byte is lost and is not retransmitted.
- FSM states: IDLE, FETCH, LOAD, START, DATA, STOP.
- IDLE: tx=1. If tx_en=1 and fifo_empty=0, go to FETCH.
- FETCH (1 cycle):
  - fifo_rd=1 during exactly this cycle; the FIFO advances its rptr and updates data_out on the closing edge.
  - fifo_rd is never high in any other state.
  - Go to LOAD.
- LOAD (1 cycle): capture fifo_data into the shift register, then go to START.
  - fifo_empty is not sampled in FETCH or LOAD, so a second pop cannot happen before the first byte is captured.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - Send 8 bits, LSB first, each held for CLKS_PER_BIT cycles.
  - Bit index is 3 bits; it increments at each bit boundary and leaves DATA after index 7.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - On the last cycle: tx_done=1 for one cycle, frames_sent increments (modulo 2^CNT_W), next state IDLE.
- Baud counter:
  - Width = clog2(CLKS_PER_BIT).
  - Reloads to 0 on each state/bit transition and counts up to CLKS_PER_BIT-1.
- Timing:
  - tx is registered and changes only on bit boundaries, so it is glitch-free.
  - Latency from IDLE seeing fifo_empty=0 to the falling edge of the start bit is 3 cycles (IDLE→FETCH→LOAD→START).
  - Back-to-back frame period with a non-empty FIFO is 10*CLKS_PER_BIT + 3 cycles.
- tx_en:
  - Dropping tx_en mid-frame has no effect until the frame returns to IDLE.
  - tx_en=0 in IDLE holds the block in IDLE and issues no fifo_rd.
- Empty FIFO: stays in IDLE, tx=1, no reads.
- FIFO refill during a frame: has no effect until IDLE. The block never reads from an empty FIFO.
- busy: equals (state != IDLE).

Test Plan:
1. Single byte (CLKS_PER_BIT=4):
   - Stimulus: push 0xA5 into the FIFO, tx_en=1.
   - Required: one fifo_rd pulse; tx sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles.
   - Required: tx_done pulses once; frames_sent=1; FIFO empty afterwards.
2. Back-to-back:
   - Stimulus: push 0x00, 0xFF, 0x3C.
   - Required: exactly 3 fifo_rd pulses, spaced 43 cycles apart.
   - Required: decoded bytes 0x00, 0xFF, 0x3C in order; frames_sent=3.
3. Flow gate:
   - Stimulus: tx_en=0 with 2 bytes queued for 100 cycles, then raise tx_en.
   - Required: no fifo_rd and tx=1 throughout the gated window; both bytes sent after tx_en=1.
   - Stimulus: drop tx_en during a DATA bit.
   - Required: the current frame completes and no new fifo_rd follows.
4. Reset mid-frame:
   - Stimulus: assert rst asynchronously during DATA bit 3.
   - Required: tx=1 and busy=0 immediately (before the next clk edge); frames_sent=0.
   - Required: after rst is released, the next queued byte is sent correctly.
5. Empty / late arrival:
   - Stimulus: FIFO empty for 50 cycles.
   - Required: no fifo_rd, busy=0.
   - Stimulus: push one byte.
   - Required: fifo_rd on the next cycle; start bit 3 cycles after empty deasserts.
6. Counter wrap:
   - Stimulus: CNT_W=2, send 5 frames.
   - Required: frames_sent reads 1,2,3,0,1.
